mips_cpu_regfile_ldq: RTL and testbench
=======================================

Name: mips_cpu_regfile_ldq

Overview:
Parametrised MIPS register file with N read ports, one ALU write port and an in-order outstanding-load queue. Loads are issued with their destination and merge type, then retire when memory data returns. Retirement applies the byte/half/lwl/lwr merge and clears a per-register busy scoreboard that the pipeline uses to stall. It sits between decode (reads), execute/writeback (ALU writes) and the data-memory response path.

Parameters:
NUM_RD, 2, number of combinational read ports (1..4)
LD_DEPTH, 4, outstanding-load queue entries (power of two, 2..16)
ADDR_W, 5, register index width; register count = 2**ADDR_W

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high reset
rd_addr  in  NUM_RD*ADDR_W  packed read selectors, port i at [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*32  packed read data
rd_busy  out  NUM_RD  register at port i has a load pending
wr_en  in  1  ALU write strobe
wr_addr  in  ADDR_W  ALU write destination
wr_data  in  32  ALU write data (full word)
ld_issue_valid  in  1  load issue request
ld_issue_ready  out  1  queue accepts issue this cycle
ld_issue_reg  in  ADDR_W  load destination
ld_issue_op  in  3  load_op_t: LW, LB, LBU, LH, LHU, LWL, LWR
ld_issue_vaddr  in  2  byte offset of effective address
ld_resp_valid  in  1  memory word returned (no backpressure)
ld_resp_data  in  32  aligned memory word
ld_err  out  1  one-cycle pulse: misaligned LH/LHU or response with empty queue
ld_count  out  $clog2(LD_DEPTH)+1  outstanding loads
regv0  out  32  debug view of register 2

Behaviour:
- Reset (async): all registers 0, queue empty, busy all 0, ld_err 0, ld_count 0; ld_issue_ready 1 on reset release.
- Register 0: reads 0, never busy, all writes to it discarded; load to $0 is queued and consumes a response, no write.
- Issue handshake: accept when ld_issue_valid && ld_issue_ready; ready = !full && !busy[ld_issue_reg]. Ready computed from current-cycle state only (no pass-through of a same-cycle retire). Accept pushes {reg, op, vaddr} and sets busy[reg] next edge.
- Retire: ld_resp_valid with queue non-empty pops the head entry; merged value written on same edge, busy[reg] cleared. Responses always retire in issue order.
- Merge (old = current register value, d = ld_resp_data, v = vaddr): LW -> d; LB/LBU -> byte v, sign/zero extended; LH/LHU -> half v[1], sign/zero extended; LWL v=0..3 -> old[31:24]/old[31:16]/old[31:8]/all replaced by d[7:0]/d[15:0]/d[23:0]/d, low bytes of old kept; LWR v=0..3 -> old[31:0]/[23:0]/[15:0]/[7:0] replaced by d/d[31:8]/d[31:16]/d[31:24], high bytes kept.
- LH/LHU with v[0]=1: entry popped, busy cleared, register unchanged, ld_err pulses.
- ld_resp_valid with empty queue: dropped, ld_err pulses.
- Simultaneous issue and retire: count unchanged; full queue with retire still refuses issue that cycle.
- ALU write: posedge write when wr_en && wr_addr!=0. wr_en to a busy register is a protocol violation (assertion; pipeline stalls on rd_busy). ALU write and retire to different registers in one cycle: both commit.
- Read bypass: rd_data shows same-cycle ALU write data or retiring merged value for a matching non-zero address; rd_busy for a register retiring this cycle reads 0. Otherwise combinational array read.
- regv0 = register 2 array value (no bypass).
- Reset mid-operation: queue discarded; late responses after reset take empty-queue path.

Decomposition:
- Package mips_cpu_pkg: load_op_t enum (3-bit), opcode-to-load_op_t mapping function, REG_ZERO/REG_V0 constants.
- Sub-module mips_cpu_load_merge: purely combinational {op, vaddr, old, d} -> {value, misalign}; reused by store-side unit later.
- Queue is a plain circular buffer with head/tail pointers and count inside the top.

Test Plan:
- Reset, ALU write $5=0x12345678, read ports 0/1 addr 5 same cycle -> bypass 0x12345678; next cycle array value identical; write $0=0xFFFFFFFF -> reads 0.
- Issue LB $8 v=3, response 0x80FF0011 -> $8=0xFFFFFF80; LBU same -> 0x00000080; busy[8] high from issue+1 until retire edge.
- $9=0xAABBCCDD; LWL v=1 d=0x11223344 -> 0x3344CCDD; then LWR v=2 d=0x55667788 -> 0x33445566.
- Issue 4 loads ($1..$4) back-to-back -> ready low at count 4; issue to busy $2 refused; retire order $1..$4 with data 1..4 -> each register equals its data.
- LH v=1 -> ld_err one cycle, register unchanged, busy cleared; ld_resp_valid with empty queue -> ld_err, no state change.
- Two loads outstanding, assert reset -> count 0, busy 0, all registers 0; following response -> ld_err, no write.

Source files
------------

// File: rtl/mips_cpu_regfile_ldq_pkg.sv
// Shared MIPS CPU types: load merge kinds, opcode decode for loads and
// architectural register numbers.
package mips_cpu_pkg;

  typedef enum logic [2:0] {
    LD_LW  = 3'd0,
    LD_LB  = 3'd1,
    LD_LBU = 3'd2,
    LD_LH  = 3'd3,
    LD_LHU = 3'd4,
    LD_LWL = 3'd5,
    LD_LWR = 3'd6
  } load_op_t;

  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_V0   = 2;

  // Primary opcode field (instr[31:26]) to merge kind; non-loads map to LW.
  function automatic load_op_t opcode_to_load_op(input logic [5:0] opcode);
    case (opcode)
      6'h20:   return LD_LB;
      6'h21:   return LD_LH;
      6'h22:   return LD_LWL;
      6'h24:   return LD_LBU;
      6'h25:   return LD_LHU;
      6'h26:   return LD_LWR;
      default: return LD_LW;
    endcase
  endfunction

endpackage

// File: rtl/mips_cpu_regfile_ldq_if.sv
// Pipeline-facing bundle of the register file: read ports, ALU write,
// load issue and memory response.
interface mips_cpu_regfile_ldq_if #(
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned LD_DEPTH = 4,
  parameter int unsigned ADDR_W   = 5
);
  localparam int unsigned CW = $clog2(LD_DEPTH) + 1;

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*32-1:0]     rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [31:0]              wr_data;
  logic                     ld_issue_valid;
  logic                     ld_issue_ready;
  logic [ADDR_W-1:0]        ld_issue_reg;
  logic [2:0]               ld_issue_op;
  logic [1:0]               ld_issue_vaddr;
  logic                     ld_resp_valid;
  logic [31:0]              ld_resp_data;
  logic                     ld_err;
  logic [CW-1:0]            ld_count;
  logic [31:0]              regv0;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data,
           ld_issue_valid, ld_issue_reg, ld_issue_op, ld_issue_vaddr,
           ld_resp_valid, ld_resp_data,
    input  rd_data, rd_busy, ld_issue_ready, ld_err, ld_count, regv0
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data,
           ld_issue_valid, ld_issue_reg, ld_issue_op, ld_issue_vaddr,
           ld_resp_valid, ld_resp_data,
    output rd_data, rd_busy, ld_issue_ready, ld_err, ld_count, regv0
  );
endinterface

// File: rtl/mips_cpu_regfile_ldq_merge.sv
// Combinational load data merge: extracts/extends sub-word loads and splices
// LWL/LWR partial words into the old register value (little-endian lanes).
module mips_cpu_load_merge
  import mips_cpu_pkg::*;
(
  input  load_op_t    op_i,
  input  logic [1:0]  vaddr_i,
  input  logic [31:0] old_i,
  input  logic [31:0] d_i,
  output logic [31:0] value_o,
  output logic        misalign_o
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v     = d_i[{vaddr_i, 3'b000} +: 8];
    half_v     = vaddr_i[1] ? d_i[31:16] : d_i[15:0];
    value_o    = d_i;
    misalign_o = 1'b0;
    case (op_i)
      LD_LB:  value_o = {{24{byte_v[7]}}, byte_v};
      LD_LBU: value_o = {24'h0, byte_v};
      LD_LH, LD_LHU: begin
        // Misaligned halfword keeps the old value; the caller flags it.
        misalign_o = vaddr_i[0];
        if (vaddr_i[0])        value_o = old_i;
        else if (op_i == LD_LH) value_o = {{16{half_v[15]}}, half_v};
        else                    value_o = {16'h0, half_v};
      end
      LD_LWL: begin
        case (vaddr_i)
          2'd0:    value_o = {d_i[7:0],  old_i[23:0]};
          2'd1:    value_o = {d_i[15:0], old_i[15:0]};
          2'd2:    value_o = {d_i[23:0], old_i[7:0]};
          default: value_o = d_i;
        endcase
      end
      LD_LWR: begin
        case (vaddr_i)
          2'd0:    value_o = d_i;
          2'd1:    value_o = {old_i[31:24], d_i[31:8]};
          2'd2:    value_o = {old_i[31:16], d_i[31:16]};
          default: value_o = {old_i[31:8],  d_i[31:24]};
        endcase
      end
      default: value_o = d_i;
    endcase
  end
endmodule

// File: rtl/mips_cpu_regfile_ldq.sv
// MIPS register file with NUM_RD bypassed read ports, one ALU write port and
// an in-order outstanding-load queue driving a per-register busy scoreboard.
module mips_cpu_regfile_ldq
  import mips_cpu_pkg::*;
#(
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned LD_DEPTH = 4,
  parameter int unsigned ADDR_W   = 5
) (
  input logic                  clk,
  input logic                  reset,
  mips_cpu_regfile_ldq_if.slave bus
);
  localparam int unsigned NREG = 2 ** ADDR_W;
  localparam int unsigned PW   = $clog2(LD_DEPTH);
  localparam int unsigned CW   = PW + 1;

  logic [31:0]       regs_q  [NREG];
  logic [NREG-1:0]   busy_q, busy_d;
  logic [ADDR_W-1:0] qreg_q  [LD_DEPTH];
  load_op_t          qop_q   [LD_DEPTH];
  logic [1:0]        qva_q   [LD_DEPTH];
  logic [PW-1:0]     head_q, tail_q;
  logic [CW-1:0]     count_q;
  logic              ld_err_q;

  logic [ADDR_W-1:0] hd_reg;
  logic              empty, full, retire, ret_we, alu_we, accept, misalign;
  logic [31:0]       merged;

  assign hd_reg = qreg_q[head_q];
  assign empty  = (count_q == '0);
  assign full   = (count_q == CW'(LD_DEPTH));
  assign retire = bus.ld_resp_valid && !empty;
  assign ret_we = retire && !misalign && (hd_reg != ADDR_W'(REG_ZERO));
  assign alu_we = bus.wr_en && (bus.wr_addr != ADDR_W'(REG_ZERO));
  assign accept = bus.ld_issue_valid && bus.ld_issue_ready;

  assign bus.ld_issue_ready = !full && !busy_q[bus.ld_issue_reg];
  assign bus.ld_err         = ld_err_q;
  assign bus.ld_count       = count_q;
  assign bus.regv0          = regs_q[REG_V0];

  mips_cpu_load_merge u_merge (
    .op_i       (qop_q[head_q]),
    .vaddr_i    (qva_q[head_q]),
    .old_i      (regs_q[hd_reg]),
    .d_i        (bus.ld_resp_data),
    .value_o    (merged),
    .misalign_o (misalign)
  );

  always_comb begin
    busy_d = busy_q;
    if (retire) busy_d[hd_reg] = 1'b0;
    if (accept && bus.ld_issue_reg != ADDR_W'(REG_ZERO)) busy_d[bus.ld_issue_reg] = 1'b1;
  end

  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      logic [ADDR_W-1:0] a;
      a = bus.rd_addr[i*ADDR_W +: ADDR_W];
      if (a == ADDR_W'(REG_ZERO))     bus.rd_data[i*32 +: 32] = '0;
      else if (ret_we && hd_reg == a) bus.rd_data[i*32 +: 32] = merged;
      else if (alu_we && bus.wr_addr == a) bus.rd_data[i*32 +: 32] = bus.wr_data;
      else                            bus.rd_data[i*32 +: 32] = regs_q[a];
      bus.rd_busy[i] = busy_q[a] && !(retire && hd_reg == a);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned r = 0; r < NREG; r++) regs_q[r] <= '0;
      for (int unsigned e = 0; e < LD_DEPTH; e++) begin
        qreg_q[e] <= '0;
        qop_q[e]  <= LD_LW;
        qva_q[e]  <= '0;
      end
      busy_q   <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      ld_err_q <= 1'b0;
    end else begin
      if (alu_we) regs_q[bus.wr_addr] <= bus.wr_data;
      if (ret_we) regs_q[hd_reg] <= merged;
      if (accept) begin
        qreg_q[tail_q] <= bus.ld_issue_reg;
        qop_q[tail_q]  <= load_op_t'(bus.ld_issue_op);
        qva_q[tail_q]  <= bus.ld_issue_vaddr;
        tail_q         <= tail_q + PW'(1);
      end
      if (retire) head_q <= head_q + PW'(1);
      count_q  <= count_q + CW'(accept) - CW'(retire);
      busy_q   <= busy_d;
      ld_err_q <= (bus.ld_resp_valid && empty) || (retire && misalign);
    end
  end

  // The pipeline must stall on rd_busy rather than overwrite a load target.
  a_no_write_busy: assert property (@(posedge clk) disable iff (reset)
    !(bus.wr_en && bus.wr_addr != ADDR_W'(REG_ZERO) && busy_q[bus.wr_addr]));

endmodule

// File: tb/tb_mips_cpu_regfile_ldq.sv
// Bench for mips_cpu_regfile_ldq: directed scenarios plus random traffic
// compared every cycle against a queue/array model of the register file.
module tb_mips_cpu_regfile_ldq;
  import mips_cpu_pkg::*;

  localparam int unsigned NUM_RD   = 2;
  localparam int unsigned LD_DEPTH = 4;
  localparam int unsigned ADDR_W   = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_cpu_regfile_ldq_if #(.NUM_RD(NUM_RD), .LD_DEPTH(LD_DEPTH), .ADDR_W(ADDR_W)) bus ();

  mips_cpu_regfile_ldq #(.NUM_RD(NUM_RD), .LD_DEPTH(LD_DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", n, act, exp);
    end
  endtask

  // Byte-lane view of the load rules.
  function automatic logic [31:0] ref_merge(input logic [2:0] op, input logic [1:0] v,
                                            input logic [31:0] old, input logic [31:0] d);
    logic [7:0] ob [4];
    logic [7:0] db [4];
    logic [7:0] rb [4];
    logic [7:0] b;
    logic [15:0] h;
    int vi;
    vi = int'(v);
    for (int j = 0; j < 4; j++) begin
      ob[j] = old[8*j +: 8];
      db[j] = d[8*j +: 8];
      rb[j] = ob[j];
    end
    case (op)
      3'd1: begin b = db[vi]; return {{24{b[7]}}, b}; end
      3'd2: begin b = db[vi]; return {24'h0, b}; end
      3'd3, 3'd4: begin
        if (v[0]) return old;
        h = {db[(vi & 2) + 1], db[vi & 2]};
        return (op == 3'd3) ? {{16{h[15]}}, h} : {16'h0, h};
      end
      3'd5: for (int j = 0; j < 4; j++) if (j >= 3 - vi) rb[j] = db[j - (3 - vi)];
      3'd6: for (int j = 0; j < 4; j++) if (j <= 3 - vi) rb[j] = db[j + vi];
      default: return d;
    endcase
    return {rb[3], rb[2], rb[1], rb[0]};
  endfunction

  typedef struct { logic [4:0] r; logic [2:0] op; logic [1:0] va; } ent_t;
  ent_t        mq[$];
  logic [31:0] mregs [32];
  logic        mbusy [32];
  logic        merr;

  task automatic model_reset();
    mq.delete();
    for (int r = 0; r < 32; r++) begin mregs[r] = '0; mbusy[r] = 1'b0; end
    merr = 1'b0;
  endtask

  initial model_reset();

  // Compare against the model, then advance the model across the coming edge.
  always @(negedge clk) begin
    if (reset) begin
      model_reset();
      chk("rst_count", 32'(bus.ld_count), 32'd0);
      chk("rst_err",   32'(bus.ld_err),   32'd0);
      chk("rst_ready", 32'(bus.ld_issue_ready), 32'd1);
    end else begin
      logic        rdy, ret, mis;
      logic [31:0] mv, ed;
      logic [4:0]  a;
      ent_t        hd;
      rdy = (mq.size() < LD_DEPTH) && !mbusy[bus.ld_issue_reg];
      ret = bus.ld_resp_valid && (mq.size() > 0);
      mis = 1'b0;
      mv  = '0;
      hd  = '{r: 5'd0, op: 3'd0, va: 2'd0};
      if (ret) begin
        hd  = mq[0];
        mis = (hd.op == 3'd3 || hd.op == 3'd4) && hd.va[0];
        mv  = ref_merge(hd.op, hd.va, mregs[hd.r], bus.ld_resp_data);
      end
      chk("ready", 32'(bus.ld_issue_ready), 32'(rdy));
      chk("count", 32'(bus.ld_count), mq.size());
      chk("err",   32'(bus.ld_err), 32'(merr));
      chk("regv0", bus.regv0, mregs[2]);
      for (int i = 0; i < NUM_RD; i++) begin
        a = bus.rd_addr[i*ADDR_W +: ADDR_W];
        if (a == 0) ed = '0;
        else if (ret && !mis && hd.r == a) ed = mv;
        else if (bus.wr_en && bus.wr_addr == a) ed = bus.wr_data;
        else ed = mregs[a];
        chk("rd_data", bus.rd_data[i*32 +: 32], ed);
        chk("rd_busy", 32'(bus.rd_busy[i]), 32'(mbusy[a] && !(ret && hd.r == a)));
      end
      merr = (bus.ld_resp_valid && mq.size() == 0) || (ret && mis);
      if (bus.wr_en && bus.wr_addr != 0) mregs[bus.wr_addr] = bus.wr_data;
      if (ret) begin
        void'(mq.pop_front());
        if (!mis && hd.r != 0) mregs[hd.r] = mv;
        mbusy[hd.r] = 1'b0;
      end
      if (bus.ld_issue_valid && rdy) begin
        mq.push_back('{r: bus.ld_issue_reg, op: bus.ld_issue_op, va: bus.ld_issue_vaddr});
        if (bus.ld_issue_reg != 0) mbusy[bus.ld_issue_reg] = 1'b1;
      end
    end
  end

  task automatic idle();
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.ld_issue_valid = 1'b0; bus.ld_issue_reg = '0; bus.ld_issue_op = '0;
    bus.ld_issue_vaddr = '0; bus.ld_resp_valid = 1'b0; bus.ld_resp_data = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic setrd(input logic [4:0] a);
    bus.rd_addr = {NUM_RD{a}};
  endtask

  task automatic peek(input string n, input logic [4:0] a, input logic [31:0] e);
    setrd(a); #1;
    chk(n, bus.rd_data[31:0], e);
    chk(n, bus.rd_data[63:32], e);
  endtask

  task automatic alu_wr(input logic [4:0] a, input logic [31:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d; step(); idle();
  endtask

  task automatic issue(input logic [4:0] r, input load_op_t op, input logic [1:0] va);
    bus.ld_issue_valid = 1'b1; bus.ld_issue_reg = r;
    bus.ld_issue_op = op; bus.ld_issue_vaddr = va;
    step(); idle();
  endtask

  task automatic resp(input logic [31:0] d);
    bus.ld_resp_valid = 1'b1; bus.ld_resp_data = d; step(); idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle();
    setrd('0);
    chk("m_lb",  ref_merge(3'(LD_LB),  2'd3, 32'h0, 32'h80FF0011), 32'hFFFFFF80);
    chk("m_lbu", ref_merge(3'(LD_LBU), 2'd3, 32'h0, 32'h80FF0011), 32'h00000080);
    chk("m_lh",  ref_merge(3'(LD_LH),  2'd2, 32'h0, 32'h80010000), 32'hFFFF8001);
    chk("m_lhu", ref_merge(3'(LD_LHU), 2'd0, 32'h0, 32'h0000F00D), 32'h0000F00D);
    chk("m_lwl", ref_merge(3'(LD_LWL), 2'd1, 32'hAABBCCDD, 32'h11223344), 32'h3344CCDD);
    chk("m_lwr", ref_merge(3'(LD_LWR), 2'd2, 32'h3344CCDD, 32'h55667788), 32'h33445566);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_cnt", 32'(bus.ld_count), 32'd0);
    chk("rst_rdy", 32'(bus.ld_issue_ready), 32'd1);

    // ALU write bypass and $0 discard
    bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 32'h12345678;
    peek("byp5", 5'd5, 32'h12345678);
    step(); idle();
    peek("arr5", 5'd5, 32'h12345678);
    bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = '1;
    peek("wr0_byp", 5'd0, 32'h0);
    step(); idle();
    peek("wr0", 5'd0, 32'h0);

    // LB / LBU with busy window
    issue(5'd8, LD_LB, 2'd3);
    setrd(5'd8); #1 chk("busy8", 32'(bus.rd_busy[0]), 32'd1);
    bus.ld_resp_valid = 1'b1; bus.ld_resp_data = 32'h80FF0011; #1;
    chk("busy8_ret", 32'(bus.rd_busy[0]), 32'd0);
    chk("lb_byp", bus.rd_data[31:0], 32'hFFFFFF80);
    step(); idle();
    peek("lb", 5'd8, 32'hFFFFFF80);
    issue(5'd8, LD_LBU, 2'd3);
    resp(32'h80FF0011);
    peek("lbu", 5'd8, 32'h00000080);

    // LWL then LWR
    alu_wr(5'd9, 32'hAABBCCDD);
    issue(5'd9, LD_LWL, 2'd1);
    resp(32'h11223344);
    peek("lwl", 5'd9, 32'h3344CCDD);
    issue(5'd9, LD_LWR, 2'd2);
    resp(32'h55667788);
    peek("lwr", 5'd9, 32'h33445566);

    // Fill the queue, refused issues, in-order retire
    for (int r = 1; r <= 4; r++) begin
      bus.ld_issue_valid = 1'b1; bus.ld_issue_reg = 5'(r); bus.ld_issue_op = LD_LW;
      #1 chk("fill_rdy", 32'(bus.ld_issue_ready), 32'd1);
      step();
    end
    idle();
    bus.ld_issue_valid = 1'b1; bus.ld_issue_reg = 5'd2;
    #1 chk("full_rdy", 32'(bus.ld_issue_ready), 32'd0);
    chk("full_cnt", 32'(bus.ld_count), 32'd4);
    bus.ld_resp_valid = 1'b1; bus.ld_resp_data = 32'd1;
    #1 chk("full_ret_rdy", 32'(bus.ld_issue_ready), 32'd0);
    step(); idle();
    bus.ld_issue_reg = 5'd2;
    #1 chk("busy2_rdy", 32'(bus.ld_issue_ready), 32'd0);
    bus.ld_issue_reg = 5'd5;
    #1 chk("free5_rdy", 32'(bus.ld_issue_ready), 32'd1);
    idle();
    for (int r = 2; r <= 4; r++) resp(32'(r));
    for (int r = 1; r <= 4; r++) begin
      peek("order", 5'(r), 32'(r));
      step();
    end
    chk("drain_cnt", 32'(bus.ld_count), 32'd0);

    // Misaligned LH and empty-queue response
    alu_wr(5'd10, 32'hCAFEBABE);
    issue(5'd10, LD_LH, 2'd1);
    resp(32'h1234ABCD);
    chk("lh_err", 32'(bus.ld_err), 32'd1);
    peek("lh_keep", 5'd10, 32'hCAFEBABE);
    chk("lh_busy", 32'(bus.rd_busy[0]), 32'd0);
    step();
    chk("lh_err_end", 32'(bus.ld_err), 32'd0);
    resp(32'hDEADBEEF);
    chk("empty_err", 32'(bus.ld_err), 32'd1);
    chk("empty_cnt", 32'(bus.ld_count), 32'd0);
    step();
    chk("empty_err_end", 32'(bus.ld_err), 32'd0);

    // Reset with loads outstanding
    issue(5'd11, LD_LW, 2'd0);
    issue(5'd12, LD_LW, 2'd0);
    chk("pre_rst_cnt", 32'(bus.ld_count), 32'd2);
    reset = 1'b1;
    #1 chk("mid_rst_cnt", 32'(bus.ld_count), 32'd0);
    peek("mid_rst_reg", 5'd9, 32'h0);
    setrd(5'd11); #1 chk("mid_rst_busy", 32'(bus.rd_busy[0]), 32'd0);
    step();
    reset = 1'b0;
    resp(32'hFFFFFFFF);
    chk("late_err", 32'(bus.ld_err), 32'd1);
    peek("late_nowr", 5'd12, 32'h0);
    step();

    // Random traffic over a small register window
    for (int c = 0; c < 3000; c++) begin
      idle();
      if ($urandom_range(399) == 0) begin
        reset = 1'b1; step(); reset = 1'b0;
        continue;
      end
      bus.rd_addr = {5'($urandom_range(7)), 5'($urandom_range(7))};
      bus.wr_addr = 5'($urandom_range(7));
      bus.wr_data = $urandom;
      bus.wr_en   = ($urandom_range(2) == 0) && !mbusy[bus.wr_addr];
      bus.ld_issue_valid = ($urandom_range(1) == 0);
      bus.ld_issue_reg   = 5'($urandom_range(7));
      bus.ld_issue_op    = 3'($urandom_range(6));
      bus.ld_issue_vaddr = 2'($urandom_range(3));
      bus.ld_resp_valid  = ($urandom_range(4) < 2);
      bus.ld_resp_data   = $urandom;
      step();
    end
    idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
